// File: rtl/core_bpu_pkg.sv
// rtl/core_bpu_pkg.sv - shared types and constants for the next-PC unit
package core_bpu_pkg;

    typedef logic [1:0] ctr2_t;

    typedef enum logic [2:0] {
        CAUSE_NONE,
        CAUSE_HANDLER,
        CAUSE_ERET,
        CAUSE_MISPRED,
        CAUSE_JUMP,
        CAUSE_PRED
    } redirect_cause_t;

    localparam ctr2_t CTR_INIT_RESET = 2'b01;
    localparam ctr2_t CTR_INIT_ALLOC = 2'b10;

endpackage

// File: rtl/core_bpu_sat_ctr2.sv
// rtl/core_bpu_sat_ctr2.sv - combinational 2-bit saturating counter update
module sat_ctr2
    import core_bpu_pkg::*;
(
    input  ctr2_t ctr,
    input  logic  taken,
    output ctr2_t ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken && ctr != 2'b11) begin
            ctr_next = ctr + 2'd1;
        end else if (!taken && ctr != 2'b00) begin
            ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/core_bpu.sv
// rtl/core_bpu.sv - next-PC selection with direct-mapped BTB and handler vector
module core_bpu
    import core_bpu_pkg::*;
#(
    parameter int               XLEN        = 64,
    parameter int               ENTRIES     = 16,
    parameter int               TAG_BITS    = 10,
    parameter logic [XLEN-1:0]  RESET_PC    = '0,
    parameter logic [XLEN-1:0]  HANDLER_VEC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] if_pc,
    input  logic            stall,
    input  logic            taken_handler,
    input  logic            eret,
    input  logic [XLEN-1:0] epc,
    input  logic            vec_we,
    input  logic [XLEN-1:0] vec_wdata,
    input  logic            id_jump_valid,
    input  logic [XLEN-1:0] id_jump_target,
    input  logic            ex_br_valid,
    input  logic [XLEN-1:0] ex_br_pc,
    input  logic            ex_br_taken,
    input  logic [XLEN-1:0] ex_br_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic [XLEN-1:0] next_pc,
    output logic            flush,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    output logic [31:0]     mispredict_count
);

    localparam int IDX_W = $clog2(ENTRIES);

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        logic [XLEN-1:0]     target;
    } btb_entry_t;

    btb_entry_t      btb_q [ENTRIES];
    btb_entry_t      btb_d [ENTRIES];
    ctr2_t           ctr_q [ENTRIES];
    ctr2_t           ctr_d [ENTRIES];
    logic [XLEN-1:0] vec_q, vec_d;
    logic [31:0]     cnt_q, cnt_d;

    logic [IDX_W-1:0]    if_idx, upd_idx;
    logic [TAG_BITS-1:0] if_tag, upd_tag;
    logic [XLEN-1:0]     if_pc_plus4, fixup_pc;
    logic                lk_hit, upd_hit, mispredict;
    ctr2_t               upd_ctr_next;
    redirect_cause_t     cause;

    assign if_idx      = if_pc[IDX_W+1:2];
    assign if_tag      = if_pc[IDX_W+2+TAG_BITS-1:IDX_W+2];
    assign upd_idx     = ex_br_pc[IDX_W+1:2];
    assign upd_tag     = ex_br_pc[IDX_W+2+TAG_BITS-1:IDX_W+2];
    assign if_pc_plus4 = if_pc + XLEN'(4);

    // Lookup reads only registered state, so a same-cycle update is not bypassed.
    assign lk_hit      = btb_q[if_idx].valid && (btb_q[if_idx].tag == if_tag);
    assign pred_taken  = !reset && lk_hit && ctr_q[if_idx][1];
    assign pred_target = (!reset && lk_hit) ? btb_q[if_idx].target : if_pc_plus4;

    assign upd_hit    = btb_q[upd_idx].valid && (btb_q[upd_idx].tag == upd_tag);
    assign mispredict = ex_br_valid && ((ex_br_taken != ex_pred_taken) ||
                        (ex_br_taken && (ex_br_target != ex_pred_target)));
    assign fixup_pc   = ex_br_taken ? ex_br_target : (ex_br_pc + XLEN'(4));

    sat_ctr2 u_sat_ctr2 (
        .ctr      (ctr_q[upd_idx]),
        .taken    (ex_br_taken),
        .ctr_next (upd_ctr_next)
    );

    always_comb begin
        cause = CAUSE_NONE;
        if (taken_handler)           cause = CAUSE_HANDLER;
        else if (eret)               cause = CAUSE_ERET;
        else if (mispredict)         cause = CAUSE_MISPRED;
        else if (id_jump_valid)      cause = CAUSE_JUMP;
        else if (!stall && pred_taken) cause = CAUSE_PRED;
    end

    always_comb begin
        next_pc = stall ? if_pc : if_pc_plus4;
        flush   = 1'b1;
        case (cause)
            CAUSE_HANDLER: next_pc = vec_q;
            CAUSE_ERET:    next_pc = epc;
            CAUSE_MISPRED: next_pc = fixup_pc;
            CAUSE_JUMP:    next_pc = id_jump_target;
            CAUSE_PRED: begin
                next_pc = pred_target;
                flush   = 1'b0;
            end
            default:       flush   = 1'b0;
        endcase
        if (reset) begin
            next_pc = RESET_PC;
            flush   = 1'b1;
        end
    end

    always_comb begin
        btb_d = btb_q;
        ctr_d = ctr_q;
        vec_d = vec_we ? vec_wdata : vec_q;
        cnt_d = (mispredict && cnt_q != 32'hFFFF_FFFF) ? cnt_q + 32'd1 : cnt_q;
        if (ex_br_valid) begin
            if (upd_hit) begin
                ctr_d[upd_idx] = upd_ctr_next;
                if (ex_br_taken) btb_d[upd_idx].target = ex_br_target;
            end else if (ex_br_taken) begin
                btb_d[upd_idx] = '{valid: 1'b1, tag: upd_tag, target: ex_br_target};
                ctr_d[upd_idx] = CTR_INIT_ALLOC;
            end
        end
        // Clearing valid is enough to discard any tag/target written this cycle.
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_d[i].valid = 1'b0;
                ctr_d[i]       = CTR_INIT_RESET;
            end
            vec_d = HANDLER_VEC;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        btb_q <= btb_d;
        ctr_q <= ctr_d;
        vec_q <= vec_d;
        cnt_q <= cnt_d;
    end

    assign mispredict_count = cnt_q;

endmodule

// File: tb/tb_core_bpu.sv
// tb/tb_core_bpu.sv - directed self-checking bench for core_bpu
module tb_core_bpu;

    logic        clk = 1'b0;
    logic        reset, stall, taken_handler, eret, vec_we, id_jump_valid;
    logic        ex_br_valid, ex_br_taken, ex_pred_taken;
    logic [63:0] if_pc, epc, vec_wdata, id_jump_target;
    logic [63:0] ex_br_pc, ex_br_target, ex_pred_target;
    logic [63:0] next_pc, pred_target;
    logic        flush, pred_taken;
    logic [31:0] mispredict_count;

    int passed = 0;
    int total  = 0;

    core_bpu dut (
        .clk              (clk),
        .reset            (reset),
        .if_pc            (if_pc),
        .stall            (stall),
        .taken_handler    (taken_handler),
        .eret             (eret),
        .epc              (epc),
        .vec_we           (vec_we),
        .vec_wdata        (vec_wdata),
        .id_jump_valid    (id_jump_valid),
        .id_jump_target   (id_jump_target),
        .ex_br_valid      (ex_br_valid),
        .ex_br_pc         (ex_br_pc),
        .ex_br_taken      (ex_br_taken),
        .ex_br_target     (ex_br_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .next_pc          (next_pc),
        .flush            (flush),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic idle();
        reset = 0; stall = 0; taken_handler = 0; eret = 0; vec_we = 0;
        id_jump_valid = 0; ex_br_valid = 0; ex_br_taken = 0; ex_pred_taken = 0;
        epc = 0; vec_wdata = 0; id_jump_target = 0;
        ex_br_pc = 0; ex_br_target = 0; ex_pred_target = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic branch(input logic [63:0] pc, input logic tk, input logic [63:0] tgt,
                          input logic ptk, input logic [63:0] ptgt);
        ex_br_valid = 1; ex_br_pc = pc; ex_br_taken = tk; ex_br_target = tgt;
        ex_pred_taken = ptk; ex_pred_target = ptgt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        if_pc = 64'h100;
        reset = 1;
        #2;
        check("rst_next_pc", next_pc, 64'h0);
        check("rst_flush", flush, 1);
        check("rst_pred_taken", pred_taken, 0);
        check("rst_pred_target", pred_target, 64'h104);
        tick();

        #1;
        check("idle_next_pc", next_pc, 64'h104);
        check("idle_flush", flush, 0);
        check("idle_pred_taken", pred_taken, 0);
        check("idle_count", mispredict_count, 0);

        branch(64'h200, 1, 64'h80, 0, 64'h0);
        #1;
        check("alloc_flush", flush, 1);
        check("alloc_next_pc", next_pc, 64'h80);
        tick();
        if_pc = 64'h200;
        #1;
        check("alloc_count", mispredict_count, 1);
        check("hit_pred_taken", pred_taken, 1);
        check("hit_pred_target", pred_target, 64'h80);
        check("hit_next_pc", next_pc, 64'h80);
        check("hit_flush", flush, 0);

        branch(64'h200, 0, 64'h80, 1, 64'h80);
        #1;
        check("nt1_flush", flush, 1);
        check("nt1_next_pc", next_pc, 64'h204);
        tick();
        if_pc = 64'h200;
        branch(64'h200, 0, 64'h80, 0, 64'h204);
        #1;
        check("nt2_flush", flush, 0);
        check("nt2_pred_taken", pred_taken, 0);
        check("nt2_next_pc", next_pc, 64'h204);
        tick();
        if_pc = 64'h200;
        #1;
        check("weak_nt_pred_taken", pred_taken, 0);
        check("weak_nt_pred_target", pred_target, 64'h80);
        check("nt_count", mispredict_count, 2);

        if_pc = 64'h100;
        taken_handler = 1; eret = 1; epc = 64'h500; id_jump_valid = 1; id_jump_target = 64'h40;
        vec_we = 1; vec_wdata = 64'h8000;
        branch(64'h610, 1, 64'h700, 0, 64'h0);
        #1;
        check("prio_handler_pc", next_pc, 64'h0);
        check("prio_handler_flush", flush, 1);
        tick();
        taken_handler = 1;
        #1;
        check("new_vec_pc", next_pc, 64'h8000);
        check("prio_count", mispredict_count, 3);
        eret = 1; epc = 64'h500; id_jump_valid = 1; id_jump_target = 64'h40;
        taken_handler = 0;
        #1;
        check("eret_pc", next_pc, 64'h500);
        tick();
        id_jump_valid = 1; id_jump_target = 64'h40;
        branch(64'h610, 0, 64'h700, 1, 64'h700);
        #1;
        check("mispred_over_jump", next_pc, 64'h614);
        check("mispred_over_jump_flush", flush, 1);
        tick();

        if_pc = 64'h300; stall = 1;
        #1;
        check("stall_pc", next_pc, 64'h300);
        check("stall_flush", flush, 0);
        id_jump_valid = 1; id_jump_target = 64'h40;
        #1;
        check("stall_jump_pc", next_pc, 64'h40);
        check("stall_jump_flush", flush, 1);
        tick();

        if_pc = 64'h100;
        branch(64'h200, 1, 64'h80, 0, 64'h204);
        tick();
        branch(64'h200, 1, 64'h80, 0, 64'h204);
        tick();
        if_pc = 64'h200;
        #1;
        check("retrain_count", mispredict_count, 6);
        check("retrain_pred_taken", pred_taken, 1);
        if_pc = 64'h240;
        #1;
        check("alias_pred_taken", pred_taken, 0);
        check("alias_pred_target", pred_target, 64'h244);
        check("alias_next_pc", next_pc, 64'h244);

        branch(64'h200, 1, 64'h80, 1, 64'h80);
        #1;
        check("correct_taken_flush", flush, 0);
        tick();
        branch(64'h200, 1, 64'h80, 1, 64'h90);
        #1;
        check("bad_target_flush", flush, 1);
        check("bad_target_next_pc", next_pc, 64'h80);
        tick();
        #1;
        check("bad_target_count", mispredict_count, 7);

        if_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        #1;
        check("wrap_next_pc", next_pc, 64'h0);

        reset = 1;
        branch(64'h900, 1, 64'hA00, 0, 64'h0);
        tick();
        if_pc = 64'h200;
        #1;
        check("post_rst_pred_taken", pred_taken, 0);
        check("post_rst_pred_target", pred_target, 64'h204);
        check("post_rst_count", mispredict_count, 0);
        if_pc = 64'h900;
        #1;
        check("discarded_alloc", pred_target, 64'h904);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
